// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 pixel timing from a sampled divider output.
// Counters, syncs and pulses are registered and decoded from next counts.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       divided_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       div_d;
  logic       pix_en;
  logic       h_wrap;
  logic [9:0] nx;
  logic [9:0] ny;
  logic       h_act;
  logic       v_act;
  logic       vis;
  logic       ls_d;
  logic       fs_d;

  assign pix_en = divided_clk & ~div_d;

  // Next counter values and the decodes taken from them
  always_comb begin
    nx     = pixel_x;
    ny     = pixel_y;
    h_wrap = 1'b0;
    if (pix_en) begin
      if (pixel_x == H_LAST) begin
        nx     = '0;
        h_wrap = 1'b1;
      end else begin
        nx = pixel_x + 10'd1;
      end
      if (h_wrap) begin
        if (pixel_y == V_LAST) ny = '0;
        else                   ny = pixel_y + 10'd1;
      end
    end
    h_act = (nx >= HS_BEG) && (nx <= HS_END);
    v_act = (ny >= VS_BEG) && (ny <= VS_END);
    vis   = (nx < H_VIS) && (ny < V_VIS);
    ls_d  = pix_en && (nx == '0);
    fs_d  = ls_d && (ny == '0);
  end

  // Edge-detect register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_d       <= 1'b0;
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_d       <= divided_clk;
      pixel_x     <= nx;
      pixel_y     <= ny;
      hsync       <= h_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= v_act ? SYNC_POL : ~SYNC_POL;
      video_on    <= vis;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks vga_sync_gen against a pixel-count model.
// A default instance and a small, positive-polarity instance share stimulus.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ls;
    logic       fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       divided_clk = 1'b0;

  logic       hs_a, vs_a, vo_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, vo_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .rst_n(rst_n), .divided_clk(divided_clk),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .pixel_x(x_a), .pixel_y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .divided_clk(divided_clk),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .pixel_x(x_b), .pixel_y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // Model state: number of pixel events since reset
  int n = 0;
  bit prev = 1'b0;
  bit fired = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      prev = 1'b0;
      fired = 1'b0;
    end else begin
      fired = divided_clk && !prev;
      if (fired) n = n + 1;
      prev = divided_clk;
    end
  end

  function automatic obs_t model(input int cnt, input bit f,
      input int ha, input int hf, input int hsw, input int hb,
      input int va, input int vf, input int vsw, input int vb,
      input bit pol);
    obs_t r;
    int ht, vt, tot, p, x, y;
    bit ha_on, va_on;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    tot = ht * vt;
    p = (cnt + tot - 1) % tot;
    x = p % ht;
    y = p / ht;
    ha_on = (x >= ha + hf) && (x < ha + hf + hsw);
    va_on = (y >= va + vf) && (y < va + vf + vsw);
    r.x  = 10'(x);
    r.y  = 10'(y);
    r.hs = ha_on ? pol : !pol;
    r.vs = va_on ? pol : !pol;
    r.vo = (x < ha) && (y < va);
    r.ls = f && (x == 0);
    r.fs = f && (x == 0) && (y == 0);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(posedge clk) begin
    obs_t ea, eb, ga, gb;
    #1;
    ea = model(n, fired, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    eb = model(n, fired, 8, 2, 3, 2, 6, 1, 2, 2, 1'b1);
    ga = '{x_a, y_a, hs_a, vs_a, vo_a, ls_a, fs_a};
    gb = '{x_b, y_b, hs_b, vs_b, vo_b, ls_b, fs_b};
    tests = tests + 2;
    if (ga !== ea) begin
      fails = fails + 1;
      $display("FAIL model_a n=%0d: got x=%0d y=%0d hs%b vs%b vo%b ls%b fs%b, expected x=%0d y=%0d hs%b vs%b vo%b ls%b fs%b",
        n, ga.x, ga.y, ga.hs, ga.vs, ga.vo, ga.ls, ga.fs,
        ea.x, ea.y, ea.hs, ea.vs, ea.vo, ea.ls, ea.fs);
    end
    if (gb !== eb) begin
      fails = fails + 1;
      $display("FAIL model_b n=%0d: got x=%0d y=%0d hs%b vs%b vo%b ls%b fs%b, expected x=%0d y=%0d hs%b vs%b vo%b ls%b fs%b",
        n, gb.x, gb.y, gb.hs, gb.vs, gb.vo, gb.ls, gb.fs,
        eb.x, eb.y, eb.hs, eb.vs, eb.vo, eb.ls, eb.fs);
    end
  end

  int hs_lo, vo_lo, ls_cnt, fs_cnt;
  int vs_on_b, ls_b_cnt, fs_b_cnt, both_b;

  task automatic clr();
    hs_lo = 0; vo_lo = 0; ls_cnt = 0; fs_cnt = 0;
    vs_on_b = 0; ls_b_cnt = 0; fs_b_cnt = 0; both_b = 0;
  endtask

  task automatic run_pix(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk) divided_clk = 1'b1;
      @(posedge clk);
      #1;
      if (y_a == 10'd0 && !hs_a) hs_lo = hs_lo + 1;
      if (y_a == 10'd0 && !vo_a) vo_lo = vo_lo + 1;
      if (ls_a) ls_cnt = ls_cnt + 1;
      if (fs_a) fs_cnt = fs_cnt + 1;
      if (vs_b) vs_on_b = vs_on_b + 1;
      if (ls_b) ls_b_cnt = ls_b_cnt + 1;
      if (fs_b) fs_b_cnt = fs_b_cnt + 1;
      if (ls_b && fs_b) both_b = both_b + 1;
      @(negedge clk);
      @(negedge clk) divided_clk = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    repeat (5) @(negedge clk);
    #1;
    chk("rst_x", x_a, 799);
    chk("rst_y", y_a, 524);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_vo", vo_a, 0);
    chk("rst_pulses", {ls_a, fs_a}, 0);
    chk("rst_s_x", x_b, 14);
    chk("rst_s_sync", {hs_b, vs_b}, 0);

    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    clr();
    run_pix(1);
    chk("first_x", x_a, 0);
    chk("first_y", y_a, 0);
    chk("first_vo", vo_a, 1);
    chk("first_fs", fs_cnt, 1);
    chk("first_ls", ls_cnt, 1);
    chk("first_pulse_gone", {ls_a, fs_a}, 0);

    clr();
    run_pix(299);
    chk("cadence_x299", x_a, 299);

    @(negedge clk) divided_clk = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk("stall_hi_x", x_a, 300);
    divided_clk = 1'b0;
    repeat (2) @(negedge clk);
    divided_clk = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_x", x_a, 301);
    @(negedge clk);
    @(negedge clk) divided_clk = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("stall_lo_x", x_a, 301);
    divided_clk = 1'b1;
    @(negedge clk) divided_clk = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("glitch_x", x_a, 302);

    run_pix(498);
    chk("line_x", x_a, 0);
    chk("line_y", y_a, 1);
    chk("line_ls", ls_cnt, 1);
    chk("line_fs", fs_cnt, 0);
    chk("hs_window", hs_lo, 96);
    chk("vo_blank", vo_lo, 160);
    chk("small_x", x_b, 5);
    chk("small_y", y_b, 9);

    clr();
    run_pix(165);
    chk("frame_s_fs", fs_b_cnt, 1);
    chk("frame_s_both", both_b, 1);
    chk("frame_s_ls", ls_b_cnt, 11);
    chk("frame_s_vs", vs_on_b, 30);
    chk("frame_s_x", x_b, 5);
    chk("frame_s_y", y_b, 9);
    chk("after_a_x", x_a, 165);

    @(negedge clk) begin
      rst_n = 1'b0;
      divided_clk = 1'b0;
    end
    #1;
    chk("mid_rst_x", x_a, 799);
    chk("mid_rst_y", y_a, 524);
    chk("mid_rst_sync", {hs_a, vs_a}, 3);
    chk("mid_rst_vo", vo_a, 0);
    chk("mid_rst_s_sync", {hs_b, vs_b}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    run_pix(1);
    chk("restart_xy", {x_a, y_a}, 0);
    chk("restart_fs", fs_cnt, 1);
    chk("restart_vo", vo_a, 1);
    run_pix(3);
    chk("restart_x3", x_a, 3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
